run_detector: RTL and testbench
===============================

# run_detector

Parametrised run-length detector for a serial bit stream: flags when RUN_LEN consecutive valid samples of a selectable polarity have been seen. It generalises the fixed four-ones detector with:
- programmable run length;
- polarity select;
- a sample-valid qualifier;
- three output modes;
- a live run-count output.

It sits directly behind serial input synchronisers, feeding control logic that needs level or pulse event indications.

## Interface
- RUN_LEN, 4, number of consecutive matching samples required; legal range 1..255
- CNT_W, $clog2(RUN_LEN+1), width of run_count; derived, never overridden
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in  input  1  serial data bit
- in_valid  input  1  sample qualifier; state holds when low
- pol  input  1  0 = detect runs of 1s, 1 = detect runs of 0s
- mode  input  2  00 LEVEL, 01 PULSE, 10 REPEAT, 11 reserved (treated as LEVEL)
- hit  output  1  detection indication, Moore output decoded from state
- run_count  output  CNT_W  current matching-run length
- hit_total  output  16  saturating detection count; present only with RUN_DET_STATS_EN

## Operation
- match = in_valid & (in ^ pol).
- States:
  - IDLE: count 0.
  - RUN: count 1..RUN_LEN-1.
  - HIT: count RUN_LEN, hit=1.
  - HOLD: count RUN_LEN, hit=0; PULSE mode only.
- in_valid=0: state and count unchanged, regardless of in.
- in_valid=1 and !match: next state IDLE, count 0, from every state.
- On match:
  - IDLE → RUN, count 1; goes straight to HIT if RUN_LEN=1.
  - RUN → count+1; enters HIT when count+1 == RUN_LEN.
  - HIT in LEVEL → stays in HIT; count saturates at RUN_LEN.
  - HIT in PULSE → HOLD.
  - HIT in REPEAT → RUN with count 1; stays in HIT, count RUN_LEN, if RUN_LEN=1.
  - HOLD → stays in HOLD.
- Config change: pol and mode are registered each cycle. If either differs from its registered value while in_valid=1, that sample is ignored and the state is forced to IDLE, count 0.
- Reserved mode 11 is decoded as LEVEL everywhere.
- run_count arithmetic is unsigned CNT_W bits and never exceeds RUN_LEN, so there is no wrap.

## Timing
- Reset (rst=1 at a clk edge) gives:
  - state IDLE;
  - hit=0;
  - run_count=0;
  - hit_total=0;
  - registered pol/mode = 0/00.
- Reset overrides all inputs, including mid-run and while in HIT.
- Latency: the Nth matching sample is captured at edge k; hit is high in the cycle following edge k. There is no combinational path from in to hit.
- LEVEL: hit stays high for every subsequent cycle until a mismatching valid sample is clocked.
- PULSE: hit is high for exactly one cycle per run. The next pulse needs a mismatch followed by RUN_LEN matches.
- REPEAT: hit pulses every RUN_LEN matching valid samples. Invalid cycles stretch the spacing but do not reset it.
- An in_valid=0 cycle while in HIT keeps hit high for that cycle, in all modes.

## Configuration
- Macro RUN_DET_STATS_EN enables the stats feature.
- Defined:
  - the hit_total port exists;
  - it increments by 1 on every transition into HIT, including REPEAT re-entries and HIT→HIT when RUN_LEN=1 in REPEAT;
  - it does not increment while LEVEL stays in HIT;
  - it saturates at 16'hFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package run_det_pkg holds:
  - the state typedef (IDLE, RUN, HIT, HOLD);
  - mode encoding constants MODE_LEVEL, MODE_PULSE, MODE_REPEAT;
  - the hit_total width constant (16).
- One sub-module, sat_counter: a parametrised width saturating incrementer with a synchronous clear. It is used for run_count and for hit_total.

## Test plan
- RUN_LEN=4, LEVEL, pol=0, in=1 for 6 valid cycles, then 0 → hit high from the cycle after the 4th sample through the cycle after the 6th; run_count goes 1,2,3,4,4,4,0.
- PULSE, pol=1, in=0 for 10 cycles → exactly one hit cycle (after the 4th); run_count holds at 4; hit_total=1.
- REPEAT, in=1 for 12 cycles → hit pulses after samples 4, 8 and 12; hit_total=3.
- in=1,1,1 valid, then 3 cycles with in_valid=0 and in=0, then in=1 valid → hit after the 4th valid sample; run_count holds at 3 during the gap.
- Mid-run pol toggle after 3 ones, or rst asserted while in HIT → next cycle run_count=0 and hit=0.
- RUN_LEN=1 in REPEAT with in=1 continuously → hit high every cycle; hit_total increments every cycle and saturates at 16'hFFFF; with the macro undefined, the bench checks port absence.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared types and constants for the run_detector block.
// The statistics counter is built only when RUN_DET_STATS_EN is defined.
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [1:0] MODE_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_REPEAT = 2'b10;

  localparam int unsigned HIT_TOTAL_W = 16;

  // Reserved encoding 11 behaves exactly like LEVEL.
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    logic [1:0] d;
    case (m)
      MODE_PULSE:  d = MODE_PULSE;
      MODE_REPEAT: d = MODE_REPEAT;
      default:     d = MODE_LEVEL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating incrementer with synchronous clear; clear and increment in the
// same cycle restart the count at one.
module sat_counter #(
  parameter int unsigned   W   = 4,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] base_s;

  // Starting point for this cycle's update: zero on clear, else the held value
  always_comb begin
    if (clr) begin
      base_s = {W{1'b0}};
    end else begin
      base_s = cnt_r;
    end
  end

  // Count register, pinned at MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (base_s != MAX)) begin
      cnt_r <= base_s + W'(1);
    end else begin
      cnt_r <= base_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive valid samples of the selected polarity.
// Define RUN_DET_STATS_EN to add the saturating hit_total counter port.
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   pol,
  input  logic [1:0]             mode,
  output logic                   hit,
  output logic [CNT_W-1:0]       run_count
`ifdef RUN_DET_STATS_EN
  ,
  output logic [HIT_TOTAL_W-1:0] hit_total
`endif
);

  state_t     state_r;
  state_t     next_state_s;
  logic       hit_r;
  logic       pol_r;
  logic [1:0] mode_r;
  logic [1:0] mode_s;
  logic       match_s;
  logic       cfg_chg_s;
  logic       last_s;
  logic       cnt_clr_s;
  logic       cnt_inc_s;
  logic       enter_hit_s;

  assign match_s   = in_valid & (in ^ pol);
  assign cfg_chg_s = (pol != pol_r) || (mode != mode_r);
  assign mode_s    = decode_mode(mode);
  assign last_s    = (run_count == CNT_W'(RUN_LEN - 1));

  // Next-state and run-counter control decode
  always_comb begin
    next_state_s = state_r;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    enter_hit_s  = 1'b0;
    if (!in_valid) begin
      next_state_s = state_r;
    end else if (cfg_chg_s || !match_s) begin
      // A config change discards the sample, same as a mismatch
      next_state_s = IDLE;
      cnt_clr_s    = 1'b1;
    end else begin
      cnt_inc_s = 1'b1;
      case (state_r)
        IDLE: begin
          if (RUN_LEN == 32'sd1) begin
            next_state_s = HIT;
            enter_hit_s  = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        RUN: begin
          if (last_s) begin
            next_state_s = HIT;
            enter_hit_s  = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        HIT: begin
          case (mode_s)
            MODE_PULSE: next_state_s = HOLD;
            MODE_REPEAT: begin
              cnt_clr_s = 1'b1;
              if (RUN_LEN == 32'sd1) begin
                next_state_s = HIT;
                enter_hit_s  = 1'b1;
              end else begin
                next_state_s = RUN;
              end
            end
            default: next_state_s = HIT;
          endcase
        end
        HOLD:    next_state_s = HOLD;
        default: begin
          next_state_s = IDLE;
          cnt_clr_s    = 1'b1;
        end
      endcase
    end
  end

  // State, registered hit and the config snapshot used for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      hit_r   <= 1'b0;
      pol_r   <= 1'b0;
      mode_r  <= 2'b00;
    end else begin
      state_r <= next_state_s;
      hit_r   <= (next_state_s == HIT);
      pol_r   <= pol;
      mode_r  <= mode;
    end
  end

  assign hit = hit_r;

  sat_counter #(
    .W   (CNT_W),
    .MAX (CNT_W'(RUN_LEN))
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .inc (cnt_inc_s),
    .cnt (run_count)
  );

`ifdef RUN_DET_STATS_EN
  sat_counter #(
    .W   (HIT_TOTAL_W),
    .MAX (16'hFFFF)
  ) u_hit_total (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (enter_hit_s),
    .cnt (hit_total)
  );
`endif

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector at RUN_LEN=4 (table) and RUN_LEN=1 (hand sequences).
// hit_total checks are active when RUN_DET_STATS_EN is defined.
module tb_run_detector;

  typedef struct {
    logic        rst;
    logic        din;
    logic        vld;
    logic        pol;
    logic [1:0]  mode;
    logic        hit;
    logic [2:0]  cnt;
    logic [15:0] tot;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1, a_in = 1'b0, a_vld = 1'b0, a_pol = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic        a_hit;
  logic [2:0]  a_cnt;
  logic        b_rst = 1'b1, b_in = 1'b0, b_vld = 1'b0, b_pol = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic        b_hit;
  logic [0:0]  b_cnt;
  logic [15:0] a_tot;
  logic [15:0] b_tot;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(4)) dut_a (
    .clk(clk), .rst(a_rst), .in(a_in), .in_valid(a_vld), .pol(a_pol),
    .mode(a_mode), .hit(a_hit), .run_count(a_cnt)
`ifdef RUN_DET_STATS_EN
    , .hit_total(a_tot)
`endif
  );

  run_detector #(.RUN_LEN(1)) dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .in_valid(b_vld), .pol(b_pol),
    .mode(b_mode), .hit(b_hit), .run_count(b_cnt)
`ifdef RUN_DET_STATS_EN
    , .hit_total(b_tot)
`endif
  );

`ifndef RUN_DET_STATS_EN
  assign a_tot = 16'h0000;
  assign b_tot = 16'h0000;
`endif

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic av(input logic r, input logic i, input logic v, input logic p,
                    input logic [1:0] m, input logic h, input logic [2:0] c, input logic [15:0] t);
    vec_t x;
    x.rst = r; x.din = i; x.vld = v; x.pol = p; x.mode = m;
    x.hit = h; x.cnt = c; x.tot = t;
    vq.push_back(x);
  endtask

  task automatic stepb(input int idx, input logic r, input logic i, input logic v, input logic p,
                       input logic [1:0] m, input logic h, input logic c, input logic [15:0] t);
    b_rst = r; b_in = i; b_vld = v; b_pol = p; b_mode = m;
    @(posedge clk); #1;
    chk("b_hit", idx, {31'd0, b_hit}, {31'd0, h});
    chk("b_cnt", idx, {31'd0, b_cnt}, {31'd0, c});
`ifdef RUN_DET_STATS_EN
    chk("b_tot", idx, {16'd0, b_tot}, {16'd0, t});
`endif
  endtask

  initial begin
    // reset
    av(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'd0);
    // LEVEL, pol=0: six ones then a zero
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'd1);
    av(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 16'd1);
    // switch to PULSE, pol=1 on an invalid cycle, then ten zeros
    av(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 3'd0, 16'd1);
    av(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 3'd1, 16'd1);
    av(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 3'd2, 16'd1);
    av(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 3'd3, 16'd1);
    av(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 3'd4, 16'd2);
    for (int k = 0; k < 6; k++) av(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 3'd4, 16'd2);
    av(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 3'd0, 16'd2);
    // REPEAT, pol=0, twelve ones
    av(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'd0, 16'd2);
    for (int k = 0; k < 3; k++) begin
      av(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3'd1, 16'(2 + k));
      av(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3'd2, 16'(2 + k));
      av(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3'd3, 16'(2 + k));
      av(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 3'd4, 16'(3 + k));
    end
    av(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'd4, 16'd5);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3'd1, 16'd5);
    av(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'd0, 16'd5);
    // LEVEL with an invalid gap mid-run
    av(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'd5);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 16'd5);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 16'd5);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 16'd5);
    for (int k = 0; k < 3; k++) av(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3, 16'd5);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'd6);
    av(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 16'd6);
    // reset while in HIT
    av(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 16'd0);
    // pol toggle after three ones
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0, 16'd0);
    av(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'd1, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0, 16'd0);
    // reserved mode acts as LEVEL; a mode change in HIT forces IDLE
    av(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd0, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 3'd1, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 3'd2, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 3'd3, 16'd0);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 3'd4, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 3'd4, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 16'd1);
    av(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'd2);

    for (int i = 0; i < vq.size(); i++) begin
      a_rst = vq[i].rst; a_in = vq[i].din; a_vld = vq[i].vld;
      a_pol = vq[i].pol; a_mode = vq[i].mode;
      @(posedge clk); #1;
      chk("a_hit", i, {31'd0, a_hit}, {31'd0, vq[i].hit});
      chk("a_cnt", i, {29'd0, a_cnt}, {29'd0, vq[i].cnt});
`ifdef RUN_DET_STATS_EN
      chk("a_tot", i, {16'd0, a_tot}, {16'd0, vq[i].tot});
`endif
    end

    // RUN_LEN=1: REPEAT re-enters HIT every sample, PULSE holds after one
    stepb(0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd0);
    stepb(1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++)
      stepb(2 + k, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 16'(k + 1));
    stepb(7,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd5);
    stepb(8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 16'd5);
    stepb(9,  1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 16'd6);
    stepb(10, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 16'd6);
    stepb(11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 16'd6);
    stepb(12, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 16'd6);

`ifdef RUN_DET_STATS_EN
    begin
      int low_hits;
      low_hits = 0;
      stepb(13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd0);
      stepb(14, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0);
      b_in = 1'b1; b_vld = 1'b1;
      for (int k = 0; k < 65535; k++) begin
        @(posedge clk); #1;
        if (b_hit !== 1'b1) low_hits++;
      end
      chk("b_hit_every_cycle", 15, low_hits, 32'd0);
      chk("b_tot_full", 16, {16'd0, b_tot}, 32'h0000FFFF);
      @(posedge clk); #1;
      chk("b_tot_sat", 17, {16'd0, b_tot}, 32'h0000FFFF);
      chk("b_hit_sat", 18, {31'd0, b_hit}, 32'd1);
    end
`else
    $display("hit_total port absent (RUN_DET_STATS_EN undefined)");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
